// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage divider.
package ex_div_pkg;

  localparam int DIV_DW    = 32;
  localparam int DIV_CNT_W = 6;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_FREE    = 2'b00;
  localparam div_state_t DIV_BY_ZERO = 2'b01;
  localparam div_state_t DIV_ON      = 2'b10;
  localparam div_state_t DIV_END     = 2'b11;

endpackage

// File: rtl/ex_div_if.sv
// EX <-> divider handshake: EX is the master, the divider is the slave.
interface ex_div_if
  import ex_div_pkg::*;
#(
  parameter int DW = DIV_DW
);
  logic            div_start;
  logic            div_signed;
  logic            div_annul;
  logic [DW-1:0]   div_opdata1;
  logic [DW-1:0]   div_opdata2;
  logic [2*DW-1:0] div_result;
  logic            div_ready;
  logic            stall_req;

  modport master (
    output div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    input  div_result, div_ready, stall_req
  );

  modport slave (
    input  div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    output div_result, div_ready, stall_req
  );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider: DW+1 cycles normal, 2 for divide-by-zero, 1 for early-out (DIV_EARLY_OUT_EN).
// Holds the pipeline via stall_req while busy; div_annul drops the divide without a result.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DW    = DIV_DW,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave bus
);

  div_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]   rem_q;
  logic [DW-1:0]   quo_q;
  logic [DW-1:0]   dvs_mag;
  logic [DW-1:0]   dvd_raw;
  logic            neg_quo;
  logic            neg_rem;
  logic [2*DW-1:0] result_q;

  logic [DW-1:0]   op1_mag;
  logic [DW-1:0]   op2_mag;
  logic [DW:0]     trial;
  logic            ge;
  logic [DW-1:0]   next_rem;
  logic [DW-1:0]   next_quo;

  function automatic logic [DW-1:0] magnitude(input logic [DW-1:0] v, input logic sgn);
    return (sgn && v[DW-1]) ? -v : v;
  endfunction

  function automatic logic [DW-1:0] negate_if(input logic [DW-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // quo_q starts as the dividend magnitude and fills with quotient bits from the bottom.
  always_comb begin
    op1_mag  = magnitude(bus.div_opdata1, bus.div_signed);
    op2_mag  = magnitude(bus.div_opdata2, bus.div_signed);
    trial    = {rem_q, quo_q[DW-1]};
    ge       = (trial >= {1'b0, dvs_mag});
    next_rem = ge ? (trial[DW-1:0] - dvs_mag) : trial[DW-1:0];
    next_quo = {quo_q[DW-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_mag  <= '0;
      dvd_raw  <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else if (bus.div_annul) begin
      state <= DIV_FREE;
    end else begin
      case (state)
        DIV_FREE: begin
          if (bus.div_start) begin
            dvd_raw <= bus.div_opdata1;
            dvs_mag <= op2_mag;
            quo_q   <= op1_mag;
            rem_q   <= '0;
            cnt     <= '0;
            neg_quo <= bus.div_signed & (bus.div_opdata1[DW-1] ^ bus.div_opdata2[DW-1]);
            neg_rem <= bus.div_signed & bus.div_opdata1[DW-1];
            if (bus.div_opdata2 == '0) begin
              state <= DIV_BY_ZERO;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (op1_mag < op2_mag) begin
              result_q <= {bus.div_opdata1, {DW{1'b0}}};
              state    <= DIV_END;
            end
`endif
            else begin
              state <= DIV_ON;
            end
          end
        end
        DIV_BY_ZERO: begin
          result_q <= {dvd_raw, {DW{1'b1}}};
          state    <= DIV_END;
        end
        DIV_ON: begin
          rem_q <= next_rem;
          quo_q <= next_quo;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DW - 1)) begin
            result_q <= {negate_if(next_rem, neg_rem), negate_if(next_quo, neg_quo)};
            state    <= DIV_END;
          end
        end
        DIV_END: begin
          state <= DIV_FREE;
        end
        default: begin
          state <= DIV_FREE;
        end
      endcase
    end
  end

  assign bus.div_result = result_q;
  assign bus.div_ready  = (state == DIV_END);
  assign bus.stall_req  = rst & (((state == DIV_FREE) & bus.div_start & ~bus.div_annul)
                                 | (state == DIV_BY_ZERO) | (state == DIV_ON));

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, multi-cycle corner sequences, random vs arithmetic model.
module tb_ex_div;
  localparam int DW = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_div_if #(.DW(DW)) bus();
  ex_div #(.DW(DW), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic [31:0] q;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: plain truncating arithmetic in 64-bit, divide-by-zero per the ISA rule.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint ma, mb;
    ma = s ? longint'($signed(a)) : longint'({32'd0, a});
    mb = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == 32'd0) return 2;
    if (EARLY && ma < mb) return 1;
    return 33;
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] res, output int lat, output bit stall_ok);
    @(negedge clk);
    bus.div_opdata1 = a;
    bus.div_opdata2 = b;
    bus.div_signed  = s;
    bus.div_start   = 1'b1;
    stall_ok = 1'b1;
    lat = 0;
    #1;
    if (bus.stall_req !== 1'b1) stall_ok = 1'b0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.div_ready === 1'b1) break;
      if (bus.stall_req !== 1'b1) stall_ok = 1'b0;
      if (lat > 60) break;
    end
    res = bus.div_result;
    if (bus.stall_req !== 1'b0) stall_ok = 1'b0;
    bus.div_start = 1'b0;
  endtask

  task automatic do_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp);
    logic [63:0] res;
    int lat;
    bit sok;
    run_div(a, b, s, res, lat, sok);
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat(a, b, s)));
    check({tag, "_stall"}, 64'(sok), 64'd1);
  endtask

  initial begin
    logic [63:0] prev;
    logic [31:0] a, b;
    logic        s;
    bit          saw;
    int          n;

    tbl[0] = '{32'd100,        32'd7,          1'b0, 32'h0000_0002, 32'h0000_000E};
    tbl[1] = '{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2};
    tbl[2] = '{32'd5,          32'd0,          1'b1, 32'h0000_0005, 32'hFFFF_FFFF};
    tbl[3] = '{32'd5,          32'd0,          1'b0, 32'h0000_0005, 32'hFFFF_FFFF};
    tbl[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h0000_0000, 32'h8000_0000};
    tbl[5] = '{32'd3,          32'd10,         1'b0, 32'h0000_0003, 32'h0000_0000};
    tbl[6] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[7] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFF, 32'h0000_0003};
    tbl[8] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'h0000_0000, 32'hFFFF_FFFF};
    tbl[9] = '{32'hFFFF_FFFF,  32'd1,          1'b1, 32'h0000_0000, 32'hFFFF_FFFF};

    // Reset state, with start high to show stall_req is forced low under reset.
    bus.div_start   = 1'b1;
    bus.div_signed  = 1'b0;
    bus.div_annul   = 1'b0;
    bus.div_opdata1 = 32'd9;
    bus.div_opdata2 = 32'd3;
    #12;
    check("rst_result", bus.div_result, 64'd0);
    check("rst_ready", 64'(bus.div_ready), 64'd0);
    check("rst_stall", 64'(bus.stall_req), 64'd0);
    bus.div_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      do_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, {tbl[i].r, tbl[i].q});

    // Annul mid-iteration, then annul overriding a start held in IDLE.
    prev = bus.div_result;
    @(negedge clk);
    bus.div_opdata1 = 32'd100;
    bus.div_opdata2 = 32'd7;
    bus.div_signed  = 1'b0;
    bus.div_start   = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.div_annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("annul_stall_override", 64'(bus.stall_req), 64'd0);
    check("annul_ready", 64'(bus.div_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.div_annul = 1'b0;
    bus.div_start = 1'b0;
    #1;
    check("annul_stall_idle", 64'(bus.stall_req), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_ready !== 1'b0) saw = 1'b1;
    end
    check("annul_no_ready", 64'(saw), 64'd0);
    check("annul_result_kept", bus.div_result, prev);

    // Operand changes during iteration are ignored.
    do_check("pre_opchg", 32'd1000, 32'd3, 1'b0, model(32'd1000, 32'd3, 1'b0));
    @(negedge clk);
    bus.div_opdata1 = 32'd100;
    bus.div_opdata2 = 32'd7;
    bus.div_signed  = 1'b0;
    bus.div_start   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.div_opdata1 = 32'd9;
    bus.div_opdata2 = 32'd2;
    n = 0;
    while (bus.div_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("opchg_result", bus.div_result, {32'd2, 32'd14});
    bus.div_start = 1'b0;

    // Reset pulse mid-iteration clears everything immediately.
    @(negedge clk);
    bus.div_opdata1 = 32'd100;
    bus.div_opdata2 = 32'd7;
    bus.div_start   = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_result", bus.div_result, 64'd0);
    check("midrst_ready", 64'(bus.div_ready), 64'd0);
    check("midrst_stall", 64'(bus.stall_req), 64'd0);
    bus.div_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_check("post_rst", 32'd3, 32'd10, 1'b0, {32'd3, 32'd0});

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case (i % 4)
        0: b = 32'($urandom_range(1, 15));
        1: b = $urandom >> $urandom_range(0, 31);
        2: b = $urandom;
        default: begin
          b = $urandom;
          a = 32'($urandom_range(0, 40));
        end
      endcase
      if (i % 25 == 0) b = 32'd0;
      do_check($sformatf("rnd%0d", i), a, b, s, model(a, b, s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
